frame_source_sequencer: RTL

Sequences one capture frame at a time from either the live VGA capture or the static image generator into the image-buffer-writer pixel path. Owns the `start`/`start_ack` handshakes to both sources and latches the source selection only between frames, so a frame is never spliced from two sources. Counts pixels to the frame boundary, reports completion and stalls, and presents one registered 8-bit pixel stream downstream.

---
 rtl/frame_source_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/frame_source_sequencer.sv
// frame_source_sequencer
//   Runs one capture frame at a time from either the live VGA capture or the
//   static image generator into the image-buffer-writer pixel path. The
//   source selection is latched only between frames, so a frame always comes
//   from a single source.
//
// Ports
//   clock, reset        : capture/writer clock, synchronous active-high reset
//   enable              : when low, no new frame is started
//   src_sel             : 0 = VGA, 1 = static image (sampled on IDLE->REQ)
//   start / start_ack   : frame request from the writer / one-cycle accept pulse
//   vga_*               : VGA source handshake and pixel stream
//   img_*               : static image source handshake and pixel stream
//   video, video_valid  : registered merged 8-bit pixel stream
//   frame_done          : pulse coincident with the last pixel of a frame
//   frame_count         : completed frames, wraps 255->0
//   active_src          : latched source selection
//   error               : sticky timeout flag, cleared only by reset
module frame_source_sequencer #(
   parameter int unsigned N_PIXEL = 480000,
   parameter int unsigned CNT_W   = 19,
   parameter int unsigned TIMEOUT = 1048576,
   parameter int unsigned TO_W    = 21
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic       src_sel,
   input  logic       start,
   output logic       start_ack,
   output logic       vga_start,
   input  logic       vga_start_ack,
   input  logic [7:0] vga_video,
   input  logic       vga_video_valid,
   output logic       img_start,
   input  logic       img_start_ack,
   input  logic [7:0] img_video,
   input  logic       img_video_valid,
   output logic [7:0] video,
   output logic       video_valid,
   output logic       frame_done,
   output logic [7:0] frame_count,
   output logic       active_src,
   output logic       error
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      STREAM
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] pix_cnt;
   logic [TO_W-1:0]  to_cnt;

   logic       sel_ack;
   logic       sel_valid;
   logic [7:0] sel_video;
   logic       launch;
   logic       ack_hit;
   logic       pix_hit;
   logic       last_pix;
   logic       timed_out;

   always_comb begin
      sel_ack   = active_src ? img_start_ack   : vga_start_ack;
      sel_valid = active_src ? img_video_valid : vga_video_valid;
      sel_video = active_src ? img_video       : vga_video;

      launch    = (state == IDLE) && start && enable;
      ack_hit   = (state == REQ) && sel_ack;
      pix_hit   = (state == STREAM) && sel_valid;
      last_pix  = pix_hit && (pix_cnt == CNT_W'(N_PIXEL - 1));
      // Progress in the same cycle as the last timeout count wins over abort.
      timed_out = ((state == REQ) || (state == STREAM)) && !ack_hit && !pix_hit &&
                  (to_cnt == TO_W'(TIMEOUT - 1));

      // Source requests come straight from the state, so they drop on the
      // same edge that leaves REQ (ack or timeout).
      vga_start = (state == REQ) && !active_src;
      img_start = (state == REQ) &&  active_src;

      state_nxt = state;
      case (state)
         IDLE:    if (launch) state_nxt = REQ;
         REQ:     if (ack_hit) state_nxt = STREAM;
                  else if (timed_out) state_nxt = IDLE;
         STREAM:  if (last_pix || timed_out) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         pix_cnt     <= '0;
         to_cnt      <= '0;
         active_src  <= 1'b0;
         start_ack   <= 1'b0;
         video       <= '0;
         video_valid <= 1'b0;
         frame_done  <= 1'b0;
         frame_count <= '0;
         error       <= 1'b0;
      end else begin
         state       <= state_nxt;
         start_ack   <= ack_hit;
         video_valid <= pix_hit;
         frame_done  <= last_pix;

         if (launch) active_src <= src_sel;
         if (pix_hit) video <= sel_video;
         if (last_pix) frame_count <= frame_count + 8'd1;
         if (timed_out) error <= 1'b1;

         if (last_pix || timed_out) pix_cnt <= '0;
         else if (pix_hit)          pix_cnt <= pix_cnt + CNT_W'(1);

         if ((state == IDLE) || ack_hit || pix_hit || timed_out) to_cnt <= '0;
         else                                                    to_cnt <= to_cnt + TO_W'(1);
      end
   end

endmodule
